// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake from the host plus the instruction
// memory write port driven by the loader.
//   byte_valid/byte_data : host byte offer
//   byte_ready           : loader accepts this cycle (transfer = valid & ready)
//   mem_we/mem_addr/mem_wd : one-cycle word write toward instruction memory
// Modports: master = host/memory side, slave = loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;

  modport master (output byte_valid, byte_data,
                  input  byte_ready, mem_we, mem_addr, mem_wd);
  modport slave  (input  byte_valid, byte_data,
                  output byte_ready, mem_we, mem_addr, mem_wd);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words and writes
// them to consecutive word addresses of the instruction memory, holding the
// core in reset until a full program image has been written.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle load request (honoured in IDLE/DONE only)
//   num_words  : words to load, legal 1..DEPTH, sampled with start
//   bus        : byte handshake + memory write port (slave modport)
//   busy       : receiving or writing
//   done       : image complete (level)
//   error      : sticky, last start carried an illegal num_words
//   cpu_rst_n  : active-low core reset, released only in DONE
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst_n
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_idx;
  logic [31:0]       word;
  logic              xfer, go, bad, legal, last;

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    go        = 1'b0;
    bad       = 1'b0;
    legal     = (num_words != '0) && (num_words <= (ADDR_W+1)'(DEPTH));
    last      = ({1'b0, word_idx} == count - 1'b1);
    case (state)
      IDLE, DONE: if (start) begin
        if (legal) begin
          go        = 1'b1;
          state_nxt = RECV;
        end else begin
          bad = 1'b1;
        end
      end
      RECV: begin
        // byte_ready is high exactly while in RECV, so valid alone qualifies
        xfer = bus.byte_valid;
        if (xfer && byte_idx == 2'd3) state_nxt = WRITE;
      end
      WRITE:   state_nxt = last ? DONE : RECV;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs are registered off the next state so they line up with the state
  // they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= BASE_ADDR;
      bus.mem_wd     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpu_rst_n      <= 1'b0;
      count          <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      word           <= '0;
    end else begin
      bus.byte_ready <= (state_nxt == RECV);
      bus.mem_we     <= (state_nxt == WRITE);
      busy           <= (state_nxt == RECV) || (state_nxt == WRITE);
      done           <= (state_nxt == DONE);
      cpu_rst_n      <= (state_nxt == DONE);
      if (go) begin
        count    <= num_words;
        word_idx <= '0;
        byte_idx <= '0;
        word     <= '0;
        error    <= 1'b0;
      end
      if (bad) error <= 1'b1;
      if (xfer) begin
        word[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
        byte_idx                      <= byte_idx + 2'd1;
      end
      // Final byte bypasses the packing register so the word is complete
      // in the WRITE cycle itself.
      if (xfer && byte_idx == 2'd3) begin
        bus.mem_addr <= BASE_ADDR + 32'({word_idx, 2'b00});
        bus.mem_wd   <= {bus.byte_data, word[23:0]};
      end
      if (state == WRITE && !last) word_idx <= word_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Expected writes are derived from the words
// the bench streams (little-endian split, address = 4*index) and checked by a
// per-cycle monitor; literal expectations pin the headline cases.
module tb_imem_loader;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [ADDR_W:0] num_words;
  logic            busy, done, error, cpu_rst_n;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .bus(bus),
    .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  int          errs = 0, chks = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          wr_cnt = 0, load_end = -1, after = 0;
  logic [31:0] last_addr = '0, last_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle monitor, run just after each falling edge.
  task automatic monitor();
    if (after == 1)      chk("done_after_last", 32'({busy, done, cpu_rst_n}), 32'h3);
    else if (after == 2) chk("recv_after_write", 32'({busy, done, bus.byte_ready}), 32'h5);
    after = 0;
    if (bus.mem_we === 1'b1) begin
      chk("ready_low_in_write", 32'(bus.byte_ready), 32'h0);
      if (wr_cnt < exp_addr.size()) begin
        chk("wr_addr", bus.mem_addr, exp_addr[wr_cnt]);
        chk("wr_data", bus.mem_wd, exp_data[wr_cnt]);
      end else begin
        chks++; errs++;
        $display("FAIL unexpected_write: addr %h data %h, no write expected", bus.mem_addr, bus.mem_wd);
      end
      last_addr = bus.mem_addr;
      last_wd   = bus.mem_wd;
      wr_cnt++;
      after = (wr_cnt == load_end) ? 1 : 2;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic expect_word(input int idx, input logic [31:0] w);
    exp_addr.push_back(32'(idx) * 32'd4);
    exp_data.push_back(w);
  endtask

  task automatic begin_load(input int n);
    start = 1'b1;
    num_words = (ADDR_W+1)'(n);
    if (n >= 1 && n <= DEPTH) load_end = wr_cnt + n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      chks++; errs++;
      $display("FAIL byte_timeout: byte %h not accepted, required within 50 cycles", b);
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      repeat (gap) tick();
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic check_reset(input string name);
    chk(name, 32'({bus.byte_ready, bus.mem_we, busy, done, error, cpu_rst_n}), 32'h0);
    chk({name, "_addr"}, bus.mem_addr, 32'h0);
    chk({name, "_wd"}, bus.mem_wd, 32'h0);
  endtask

  logic [31:0] w3[3];
  int          base;

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0;
    bus.byte_valid = 1'b0; bus.byte_data = '0;
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Illegal counts from IDLE
    begin_load(0);
    chk("err_zero", 32'({error, busy, done, cpu_rst_n}), 32'h8);
    begin_load(1025);
    chk("err_over", 32'({error, busy, done, cpu_rst_n}), 32'h8);
    bus.byte_valid = 1'b1; bus.byte_data = 8'hAA;
    repeat (3) tick();
    chk("no_ready_idle", 32'(bus.byte_ready), 32'h0);
    bus.byte_valid = 1'b0;
    chk("no_write_idle", 32'(wr_cnt), 32'h0);

    // Single word, back-to-back bytes
    expect_word(0, {8'h00, 8'h50, 8'h03, 8'h13});
    begin_load(1);
    chk("err_cleared", 32'(error), 32'h0);
    send_byte(8'h13); send_byte(8'h03); send_byte(8'h50); send_byte(8'h00);
    tick();
    chk("t1_wd", last_wd, 32'h00500313);
    chk("t1_addr", last_addr, 32'h0);
    chk("t1_count", 32'(wr_cnt), 32'h1);
    chk("t1_done", 32'({done, cpu_rst_n}), 32'h3);

    // Reload from DONE
    expect_word(0, 32'hDEADBEEF);
    expect_word(1, 32'h12345678);
    begin_load(2);
    chk("reload_rst", 32'({cpu_rst_n, done, busy}), 32'h1);
    send_word(32'hDEADBEEF, 0);
    send_word(32'h12345678, 0);
    tick();
    chk("reload_done", 32'({done, cpu_rst_n}), 32'h3);
    chk("reload_last_addr", last_addr, 32'h4);

    // Illegal start while DONE
    begin_load(0);
    chk("err_in_done", 32'({error, done, cpu_rst_n}), 32'h7);

    // Three words with idle gaps between bytes
    w3[0] = 32'h0BADF00D; w3[1] = 32'hCAFE0001; w3[2] = 32'h80706050;
    for (int i = 0; i < 3; i++) expect_word(i, w3[i]);
    begin_load(3);
    chk("err_cleared2", 32'(error), 32'h0);
    for (int i = 0; i < 3; i++) send_word(w3[i], i + 1);
    tick();
    chk("t2_last_addr", last_addr, 32'h8);
    chk("t2_last_wd", last_wd, 32'h80706050);
    chk("t2_done", 32'(done), 32'h1);

    // Reset in the middle of word 1
    expect_word(0, 32'hA1B2C3D4);
    base = wr_cnt;
    begin_load(2);
    send_word(32'hA1B2C3D4, 0);
    send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    rst = 1'b0;
    bus.byte_valid = 1'b1; bus.byte_data = 8'h33;
    repeat (12) tick();
    bus.byte_valid = 1'b0;
    chk("mid_rst_writes", 32'(wr_cnt - base), 32'h1);
    chk("mid_rst_cpu", 32'({cpu_rst_n, busy}), 32'h0);

    // Full-depth image
    for (int i = 0; i < DEPTH; i++) expect_word(i, (32'(i) * 32'h01010101) ^ 32'h5A00A5FF);
    base = wr_cnt;
    begin_load(DEPTH);
    for (int i = 0; i < DEPTH; i++) send_word((32'(i) * 32'h01010101) ^ 32'h5A00A5FF, 0);
    tick();
    chk("full_last_addr", last_addr, 32'hFFC);
    chk("full_count", 32'(wr_cnt - base), 32'(DEPTH));
    chk("full_done", 32'({done, cpu_rst_n, busy}), 32'h6);

    chk("all_writes_seen", 32'(wr_cnt), 32'(exp_addr.size()));
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
